stage_3_ex: RTL
===============

# stage_3_EX

Execute stage of the 5-stage LoongArch pipeline. It is the receiving end of the ID→EX handshake and of the `stage_2_to_3` bus. It registers the decoded instruction, evaluates the 12-operation one-hot ALU, issues the data-SRAM request for loads and stores, and forwards the result bus to MEM. It also drives `valid_3` and `rf_waddr_3_fwd`, which ID uses for read-after-write hazard detection.

## Interface
Parameters: none.

Clock and reset: one clock; reset is synchronous and active-high.

- `clk` in 1 – the single pipeline clock.
- `reset` in 1 – synchronous, active-high.
- `valid_2` in 1 – ID holds a valid instruction.
- `allow_3` out 1 – EX can accept an instruction this cycle.
- `valid_3` out 1 – EX holds a valid instruction.
- `allow_4` in 1 – MEM can accept an instruction this cycle.
- `stage_2_to_3` in 117 – decoded instruction bus. Field layout:
  - [116] `rf_we`
  - [115:111] `dest`
  - [110] `res_from_mem`
  - [109:78] `alu_src1`
  - [77:46] `alu_src2`
  - [45:34] `alu_op`
  - [33] `mem_we`
  - [32] `mem_en`
  - [31:0] `pc`
- `memory_write_data` in 32 – store data. Valid in the same cycle as `stage_2_to_3`.
- `stage_3_to_4` out 71 – result bus to MEM: {`rf_we`, `dest`[4:0], `res_from_mem`, `alu_result`[31:0], `pc`[31:0]}.
- `data_sram_en` out 1 – data SRAM request.
- `data_sram_we` out 4 – byte write enables.
- `data_sram_addr` out 32 – SRAM address, equal to `alu_result`.
- `data_sram_wdata` out 32 – store data.
- `rf_waddr_3_fwd` out 5 – destination of the instruction in EX. It is 0 when `rf_we`=0 or `valid_3`=0.

## Operation
- **Handshake:**
  - `readygo_3`=1; the ALU is single-cycle.
  - `allow_3` = ~`valid_3` | `allow_4`.
  - At each edge where `allow_3`=1, `valid_3` <= `valid_2`. Otherwise `valid_3` holds.
- **Capture:**
  - When `valid_2` & `allow_3`, the input bus and `memory_write_data` are latched into a 149-bit register.
  - When the capture condition is false, the register holds. A bubble does not overwrite held data.
- **ALU** (combinational on the registered operands), one-hot `alu_op`:
  - bit 0: add
  - bit 1: sub
  - bit 2: slt (signed compare) → 32'h1 or 0
  - bit 3: sltu (unsigned compare) → 32'h1 or 0
  - bit 4: and
  - bit 5: nor
  - bit 6: or
  - bit 7: xor
  - bit 8: sll by `src2`[4:0]
  - bit 9: srl by `src2`[4:0]
  - bit 10: sra by `src2`[4:0], arithmetic
  - bit 11: lu12i, result = `src2`
  - All results are OR-merged. An all-zero `alu_op` yields 0.
  - Add and sub wrap modulo 2^32; no overflow flag.
- **Memory request:**
  - `data_sram_en` = `valid_3` & `mem_en` & `allow_4`. It asserts only in the cycle the instruction advances to MEM, so each load or store issues exactly once and synchronous read data returns while the instruction is in MEM.
  - `data_sram_we` = {4{`mem_we`}} & {4{`data_sram_en`}}.
  - `data_sram_addr` = `alu_result`.
  - `data_sram_wdata` = the latched `memory_write_data`.
- **Forward address:** `rf_waddr_3_fwd` = (`valid_3` & `rf_we`) ? `dest` : 0.
- **Result bus:** `stage_3_to_4` is driven from the register and the ALU regardless of `valid_3`. MEM qualifies it with `valid_3`.

## Timing
- **Reset:**
  - `valid_3`=0 and `allow_3`=1.
  - Capture register is cleared, so `stage_3_to_4`=0 and `rf_waddr_3_fwd`=0.
  - All `data_sram_*` outputs are 0.
  - Reset has priority over capture in the same cycle. An instruction held mid-stall is discarded.
- **Latency:** accepted at edge N; `stage_3_to_4`, `valid_3` and the request are visible in cycle N+1. Leaves at the first edge with `allow_4`=1.
- **Stall** (`allow_4`=0 with `valid_3`=1):
  - `allow_3`=0; register and `valid_3` hold.
  - `data_sram_en`=0.
  - `rf_waddr_3_fwd` stays asserted, so ID keeps stalling.
- **Simultaneous leave and enter:** with `valid_3`=1, `allow_4`=1 and `valid_2`=1, the old instruction moves to MEM and the new one is captured at the same edge. Full throughput is one instruction per cycle.
- **Bubble in:** `valid_2`=0 with `allow_3`=1 → `valid_3`=0 next cycle.

## Configuration
- `EX_RESULT_FWD_EN` defined adds two outputs:
  - `rf_wdata_3_fwd` out 32 = `alu_result`.
  - `rf_fwd_ok_3` out 1 = `valid_3` & `rf_we` & ~`res_from_mem`. It tells ID it may bypass instead of stall; loads still stall.
- Undefined: both ports and their logic are absent. Hazards are resolved only by ID stalling on `rf_waddr_3_fwd`.

## Test plan
- **Add and forward address:** reset, then present add (`alu_op`=12'h001) with `src1`=32'hFFFFFFFF, `src2`=2, `rf_we`=1, `dest`=5, `allow_4`=1.
  - Next cycle: `alu_result`=1, `valid_3`=1, `rf_waddr_3_fwd`=5.
- **Stall, then store:** store (`mem_we`=`mem_en`=1, `src1`=32'h100, `src2`=8, `memory_write_data`=32'hDEADBEEF) with `allow_4`=0 for 3 cycles, then 1.
  - `data_sram_en`=0 during the stall; `allow_3`=0.
  - Exactly one cycle of `data_sram_en`=1, `we`=4'hF, `addr`=32'h108, `wdata`=32'hDEADBEEF.
- **Shift and compare:**
  - sra of 32'h80000000 by 4 → 32'hF8000000.
  - slt of -1 vs 1 → 1.
  - sltu of -1 vs 1 → 0.
  - lu12i with `src2`=32'h12345000 → 32'h12345000.
- **Back-to-back and bubbles:** three consecutive instructions with `allow_4`=1 → one result per cycle, with no duplication or drop. Then `valid_2`=0 → `valid_3`=0 and `rf_waddr_3_fwd`=0.
- **Reset mid-stall:** `reset`=1 during a stalled load → next cycle `valid_3`=0, `data_sram_en`=0, `allow_3`=1.
- **With `EX_RESULT_FWD_EN`:**
  - ALU op writing r7=42 → `rf_fwd_ok_3`=1, `rf_wdata_3_fwd`=42.
  - Load → `rf_fwd_ok_3`=0.

Source files
------------

// File: rtl/stage_3_ex.sv
// stage_3_ex: execute stage of the 5-stage LoongArch pipeline.
//   Latency: instruction accepted at edge N is visible (result bus, valid_3, SRAM request) in cycle N+1.
//   Backpressure: allow_3 = ~valid_3 | allow_4; a stalled instruction holds its register and issues no SRAM request.
// Ports:
//   clk, reset                 - pipeline clock, synchronous active-high reset
//   valid_2 / allow_3          - ID->EX handshake (allow_3 out)
//   valid_3 / allow_4          - EX->MEM handshake (valid_3 out)
//   stage_2_to_3[116:0]        - decoded instruction {rf_we,dest,res_from_mem,src1,src2,alu_op,mem_we,mem_en,pc}
//   memory_write_data[31:0]    - store data, valid alongside stage_2_to_3
//   stage_3_to_4[70:0]         - {rf_we,dest,res_from_mem,alu_result,pc} to MEM
//   data_sram_en/we/addr/wdata - data SRAM request, issued once in the cycle the instruction advances
//   rf_waddr_3_fwd[4:0]        - destination in EX for ID hazard detection (0 when none)
// Optional (macro EX_RESULT_FWD_EN):
//   rf_wdata_3_fwd[31:0]       - ALU result for ID bypass
//   rf_fwd_ok_3                - bypass allowed (valid non-load write)
module stage_3_ex (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_2,
  output logic         allow_3,
  output logic         valid_3,
  input  logic         allow_4,
  input  logic [116:0] stage_2_to_3,
  input  logic [31:0]  memory_write_data,
  output logic [70:0]  stage_3_to_4,
  output logic         data_sram_en,
  output logic [3:0]   data_sram_we,
  output logic [31:0]  data_sram_addr,
  output logic [31:0]  data_sram_wdata,
  output logic [4:0]   rf_waddr_3_fwd
`ifdef EX_RESULT_FWD_EN
  ,
  output logic [31:0]  rf_wdata_3_fwd,
  output logic         rf_fwd_ok_3
`endif
);

  logic         r_valid_3;
  logic [116:0] r_inst;
  logic [31:0]  r_wdata;

  logic         w_rf_we;
  logic [4:0]   w_dest;
  logic         w_res_from_mem;
  logic [31:0]  w_src1;
  logic [31:0]  w_src2;
  logic [11:0]  w_alu_op;
  logic         w_mem_we;
  logic         w_mem_en;
  logic [31:0]  w_pc;
  logic [31:0]  w_alu_result;
  logic [31:0]  w_sum;
  logic [31:0]  w_diff;
  logic         w_sram_en;

  assign {w_rf_we, w_dest, w_res_from_mem, w_src1, w_src2,
          w_alu_op, w_mem_we, w_mem_en, w_pc} = r_inst;

  // ALU is single-cycle, so EX is always ready to go.
  assign allow_3 = ~r_valid_3 | allow_4;
  assign valid_3 = r_valid_3;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid_3 <= 1'b0;
      r_inst    <= '0;
      r_wdata   <= '0;
    end else if (allow_3) begin
      r_valid_3 <= valid_2;
      // Bubbles leave the held payload untouched.
      if (valid_2) begin
        r_inst  <= stage_2_to_3;
        r_wdata <= memory_write_data;
      end
    end
  end

  assign w_sum  = w_src1 + w_src2;
  assign w_diff = w_src1 - w_src2;

  // One-hot op select: each lane is masked by its op bit and OR-merged,
  // so an all-zero op yields 0.
  always_comb begin
    w_alu_result = '0;
    w_alu_result = w_alu_result | ({32{w_alu_op[0]}}  & w_sum);
    w_alu_result = w_alu_result | ({32{w_alu_op[1]}}  & w_diff);
    w_alu_result = w_alu_result | ({32{w_alu_op[2]}}  &
                   {31'd0, ($signed(w_src1) < $signed(w_src2))});
    w_alu_result = w_alu_result | ({32{w_alu_op[3]}}  & {31'd0, (w_src1 < w_src2)});
    w_alu_result = w_alu_result | ({32{w_alu_op[4]}}  & (w_src1 & w_src2));
    w_alu_result = w_alu_result | ({32{w_alu_op[5]}}  & ~(w_src1 | w_src2));
    w_alu_result = w_alu_result | ({32{w_alu_op[6]}}  & (w_src1 | w_src2));
    w_alu_result = w_alu_result | ({32{w_alu_op[7]}}  & (w_src1 ^ w_src2));
    w_alu_result = w_alu_result | ({32{w_alu_op[8]}}  & (w_src1 << w_src2[4:0]));
    w_alu_result = w_alu_result | ({32{w_alu_op[9]}}  & (w_src1 >> w_src2[4:0]));
    w_alu_result = w_alu_result | ({32{w_alu_op[10]}} &
                   32'($signed(w_src1) >>> w_src2[4:0]));
    w_alu_result = w_alu_result | ({32{w_alu_op[11]}} & w_src2);
  end

  // Request only in the advancing cycle so each access issues exactly once
  // and synchronous read data lines up with the instruction in MEM.
  assign w_sram_en       = r_valid_3 & w_mem_en & allow_4;
  assign data_sram_en    = w_sram_en;
  assign data_sram_we    = {4{w_mem_we}} & {4{w_sram_en}};
  assign data_sram_addr  = w_alu_result;
  assign data_sram_wdata = r_wdata;

  assign rf_waddr_3_fwd = (r_valid_3 & w_rf_we) ? w_dest : 5'd0;

  assign stage_3_to_4 = {w_rf_we, w_dest, w_res_from_mem, w_alu_result, w_pc};

`ifdef EX_RESULT_FWD_EN
  // Loads cannot be bypassed from EX; their data arrives in MEM.
  assign rf_wdata_3_fwd = w_alu_result;
  assign rf_fwd_ok_3    = r_valid_3 & w_rf_we & ~w_res_from_mem;
`endif

endmodule
